hazard_stall_unit: RTL

//  Stall/flush controller for the five-stage pipeline with I- and D-caches. It is the

---
 rtl/hazard_stall_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_unit
//  Brief    : Stall/flush control for the 5-stage pipeline (load-use, ID
//             register branches, cache misses) plus I/D fill port arbitration.
//             Optional perf counters enabled with macro HAZ_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IF_ID_RegRs,
    input  logic [REG_W-1:0] IF_ID_RegRt,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_BranchReg,
    input  logic [REG_W-1:0] ID_EX_RegWd,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] EX_MEM_RegWd,
    input  logic             EX_MEM_MemRead,
    input  logic             BranchTaken,
    input  logic             imiss,
    input  logic             dmiss,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             Pipe_Hold,
    output logic             MEM_WB_Flush,
    output logic             MemGrantI,
    output logic             MemGrantD
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] PerfDStall,
    output logic [CNT_W-1:0] PerfIStall,
    output logic [CNT_W-1:0] PerfHzStall
`endif
);

    localparam logic [1:0] c_S_RUN    = 2'd0;
    localparam logic [1:0] c_S_D_FILL = 2'd1;
    localparam logic [1:0] c_S_I_FILL = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_stateNext;

    logic w_exWdNz;
    logic w_memWdNz;
    logic w_ldUse;
    logic w_brEx;
    logic w_brMem;
    logic w_hz;

    // Destination R0 is hardwired zero, so it can never carry a hazard.
    assign w_exWdNz  = (ID_EX_RegWd  != '0);
    assign w_memWdNz = (EX_MEM_RegWd != '0);

    assign w_ldUse = ID_EX_MemRead & w_exWdNz &
                     ((ID_EX_RegWd == IF_ID_RegRs) |
                      (IF_ID_UsesRt & (ID_EX_RegWd == IF_ID_RegRt)));
    assign w_brEx  = IF_ID_BranchReg & ID_EX_RegWrite & w_exWdNz &
                     (ID_EX_RegWd == IF_ID_RegRs);
    assign w_brMem = IF_ID_BranchReg & EX_MEM_MemRead & w_memWdNz &
                     (EX_MEM_RegWd == IF_ID_RegRs);
    assign w_hz    = w_ldUse | w_brEx | w_brMem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // An I-fill in progress is never preempted; the D side waits its turn.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_S_RUN: begin
                if (dmiss)      w_stateNext = c_S_D_FILL;
                else if (imiss) w_stateNext = c_S_I_FILL;
            end
            c_S_D_FILL: begin
                if (!dmiss) w_stateNext = imiss ? c_S_I_FILL : c_S_RUN;
            end
            c_S_I_FILL: begin
                if (!imiss) w_stateNext = dmiss ? c_S_D_FILL : c_S_RUN;
            end
            default: w_stateNext = c_S_RUN;
        endcase
    end

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        Pipe_Hold    = 1'b0;
        MEM_WB_Flush = 1'b0;
        MemGrantI    = 1'b0;
        MemGrantD    = 1'b0;
        if (rst_n) begin
            MemGrantD = (r_state == c_S_D_FILL) & dmiss;
            MemGrantI = (r_state == c_S_I_FILL) & imiss;
            if (dmiss) begin
                Pipe_Hold    = 1'b1;
                MEM_WB_Flush = 1'b1;
                PC_Write     = 1'b0;
                IF_ID_Write  = 1'b0;
            end else if (imiss) begin
                // Fetch bubble only; older instructions keep draining.
                PC_Write    = 1'b0;
                IF_ID_Flush = 1'b1;
            end else if (w_hz) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
            end else if (BranchTaken) begin
                IF_ID_Flush = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic w_dStall;
    logic w_iStall;
    logic w_hzStall;

    assign w_dStall  = Pipe_Hold;
    assign w_iStall  = rst_n & imiss & ~dmiss;
    assign w_hzStall = rst_n & w_hz & ~imiss & ~dmiss;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PerfDStall  <= '0;
            PerfIStall  <= '0;
            PerfHzStall <= '0;
        end else begin
            if (w_dStall  && !(&PerfDStall))  PerfDStall  <= PerfDStall  + 1'b1;
            if (w_iStall  && !(&PerfIStall))  PerfIStall  <= PerfIStall  + 1'b1;
            if (w_hzStall && !(&PerfHzStall)) PerfHzStall <= PerfHzStall + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
